// File: rtl/risc_datapath.sv
// Single-bus 32-bit datapath: GPRs, PC, IR, MAR, MDR, HI/LO, Y, Z
// and the ALU, all sharing one bus driven by one-hot out strobes.
module risc_datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        Read,
  input  logic [4:0]  OpCode,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MemAddr,
  output logic [31:0] IRq
);

  logic [15:0] rout;
  logic [15:0] rin;
  logic [31:0] r [16];
  logic [31:0] pc, ir, mar, mdr, hi, lo, y;
  logic [63:0] z;
  logic [31:0] bus;
  logic [63:0] z_next;

  assign rout = {R15out, R14out, R13out, R12out,
                 R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out,
                 R3out, R2out, R1out, R0out};
  assign rin  = {R15in, R14in, R13in, R12in,
                 R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in,
                 R3in, R2in, R1in, R0in};

  // Lowest priority first; later hits override, so R0 wins.
  always_comb begin
    bus = '0;
    if (MDRout)   bus = mdr;
    if (PCout)    bus = pc;
    if (Zlowout)  bus = z[31:0];
    if (Zhighout) bus = z[63:32];
    if (LOout)    bus = lo;
    if (HIout)    bus = hi;
    for (int i = 15; i >= 0; i--)
      if (rout[i]) bus = r[i];
  end

  logic [31:0] a, b;
  logic [4:0]  sh;
  logic [63:0] dbl_r, dbl_l, prod;
  logic [31:0] asr, quo, rem;

  assign a     = y;
  assign b     = bus;
  assign sh    = b[4:0];
  assign dbl_r = {a, a} >> sh;
  assign dbl_l = {a, a} << sh;
  assign prod  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign asr   = $signed(a) >>> sh;

  always_comb begin
    quo = '0;
    rem = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    z_next = '0;
    case (OpCode)
      5'd0:  z_next = {32'd0, b};
      5'd1:  z_next = {32'd0, a + b};
      5'd2:  z_next = {32'd0, a - b};
      5'd3:  z_next = {32'd0, a & b};
      5'd4:  z_next = {32'd0, a | b};
      5'd5:  z_next = {32'd0, a >> sh};
      5'd6:  z_next = {32'd0, a << sh};
      5'd7:  z_next = {32'd0, dbl_r[31:0]};
      5'd8:  z_next = {32'd0, dbl_l[63:32]};
      5'd9:  z_next = {32'd0, 32'd0 - b};
      5'd10: z_next = {32'd0, ~b};
      5'd11: z_next = {32'd0, asr};
      5'd12: z_next = {32'd0, b + 32'd1};
      5'd13: z_next = prod;
      5'd14: z_next = {rem, quo};
      default: z_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++)
        r[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      hi  <= '0;
      lo  <= '0;
      y   <= '0;
      z   <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (rin[i]) r[i] <= bus;
      if (PCin)  pc  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
      if (Yin)   y   <= bus;
      if (Zin)   z   <= z_next;
    end
  end

  assign BusMuxOut = bus;
  assign MemAddr   = mar;
  assign IRq       = ir;

endmodule

// File: tb/tb_risc_datapath.sv
// Scoreboard bench for risc_datapath: directed micro-op sequences
// plus random transfers checked against a register-level model.
module tb_risc_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] rout, rin;
  logic        hi_out, lo_out, zh_out, zl_out, pc_out, mdr_out;
  logic        pc_in, ir_in, mar_in, mdr_in, hi_in, lo_in, y_in, z_in;
  logic        read;
  logic [4:0]  opcode;
  logic [31:0] mdatain;
  logic [31:0] bus, mem_addr, irq;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .clr(clr),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]),
    .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
    .R6out(rout[6]), .R7out(rout[7]), .R8out(rout[8]),
    .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]),
    .R15out(rout[15]),
    .PCout(pc_out), .MDRout(mdr_out), .HIout(hi_out),
    .LOout(lo_out), .Zhighout(zh_out), .Zlowout(zl_out),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]),
    .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
    .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]),
    .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]),
    .R15in(rin[15]),
    .PCin(pc_in), .IRin(ir_in), .MARin(mar_in),
    .MDRin(mdr_in), .HIin(hi_in), .LOin(lo_in),
    .Yin(y_in), .Zin(z_in),
    .Read(read), .OpCode(opcode), .Mdatain(mdatain),
    .BusMuxOut(bus), .MemAddr(mem_addr), .IRq(irq)
  );

  localparam int S_HI = 16, S_LO = 17, S_ZH = 18;
  localparam int S_ZL = 19, S_PC = 20, S_MDR = 21;
  localparam int S_NONE = 31;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = (e.kind == 0) ? bus :
            (e.kind == 1) ? mem_addr : irq;
      checks++;
      if (act === e.exp) passes++;
      else $display("FAIL %s: got %h expected %h",
                    e.name, act, e.exp);
    end
  end

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
  logic [63:0] m_z;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
    m_hi = '0; m_lo = '0; m_y = '0; m_z = '0;
  endtask

  function automatic logic [31:0] mbus(int s);
    if (s < 16) return m_r[s];
    case (s)
      S_HI:  return m_hi;
      S_LO:  return m_lo;
      S_ZH:  return m_z[63:32];
      S_ZL:  return m_z[31:0];
      S_PC:  return m_pc;
      S_MDR: return m_mdr;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] alu_ref(
      logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int n;
    logic [31:0] t;
    longint sa, sbv, p, q, rm;
    n   = int'(b[4:0]);
    t   = a;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      5'd0:  return {32'd0, b};
      5'd1:  return {32'd0, a + b};
      5'd2:  return {32'd0, a - b};
      5'd3:  return {32'd0, a & b};
      5'd4:  return {32'd0, a | b};
      5'd5:  return {32'd0, a >> n};
      5'd6:  return {32'd0, a << n};
      5'd7: begin
        repeat (n) t = {t[0], t[31:1]};
        return {32'd0, t};
      end
      5'd8: begin
        repeat (n) t = {t[30:0], t[31]};
        return {32'd0, t};
      end
      5'd9:  return {32'd0, 32'd0 - b};
      5'd10: return {32'd0, ~b};
      5'd11: begin
        repeat (n) t = {t[31], t[31:1]};
        return {32'd0, t};
      end
      5'd12: return {32'd0, b + 32'd1};
      5'd13: begin
        p = sa * sbv;
        return 64'(p);
      end
      5'd14: begin
        if (b == 32'd0) return 64'd0;
        q  = sa / sbv;
        rm = sa % sbv;
        return {rm[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic clear_all();
    rout = '0; rin = '0;
    hi_out = 0; lo_out = 0; zh_out = 0;
    zl_out = 0; pc_out = 0; mdr_out = 0;
    pc_in = 0; ir_in = 0; mar_in = 0; mdr_in = 0;
    hi_in = 0; lo_in = 0; y_in = 0; z_in = 0;
    read = 0; opcode = '0;
  endtask

  task automatic drive_src(int s);
    if (s < 16) rout[s] = 1'b1;
    else case (s)
      S_HI:  hi_out = 1'b1;
      S_LO:  lo_out = 1'b1;
      S_ZH:  zh_out = 1'b1;
      S_ZL:  zl_out = 1'b1;
      S_PC:  pc_out = 1'b1;
      S_MDR: mdr_out = 1'b1;
      default: ;
    endcase
  endtask

  // od bits: 0 PC, 1 IR, 2 MAR, 3 MDR, 4 HI, 5 LO, 6 Y, 7 Z
  task automatic step(int s, logic [15:0] rd, logic [7:0] od,
                      logic [4:0] op, logic rdm, logic [31:0] md);
    logic [31:0] b;
    logic [63:0] zn;
    clear_all();
    drive_src(s);
    rin = rd;
    pc_in = od[0]; ir_in = od[1]; mar_in = od[2];
    mdr_in = od[3]; hi_in = od[4]; lo_in = od[5];
    y_in = od[6]; z_in = od[7];
    opcode = op; read = rdm; mdatain = md;
    b  = mbus(s);
    zn = alu_ref(op, m_y, b);
    @(posedge clk); #1;
    clear_all();
    for (int i = 0; i < 16; i++)
      if (rd[i]) m_r[i] = b;
    if (od[0]) m_pc = b;
    if (od[1]) m_ir = b;
    if (od[2]) m_mar = b;
    if (od[3]) m_mdr = rdm ? md : b;
    if (od[4]) m_hi = b;
    if (od[5]) m_lo = b;
    if (od[6]) m_y = b;
    if (od[7]) m_z = zn;
    sb.push_back('{name:"memaddr", kind:1, exp:m_mar});
    sb.push_back('{name:"irq", kind:2, exp:m_ir});
    @(negedge clk); #1;
  endtask

  task automatic expect_src(int s, string nm, logic [31:0] v);
    clear_all();
    drive_src(s);
    sb.push_back('{name:nm, kind:0, exp:v});
    @(negedge clk); #1;
    clear_all();
  endtask

  task automatic observe(int s, string nm);
    expect_src(s, nm, mbus(s));
  endtask

  task automatic expect_kind(int k, string nm, logic [31:0] v);
    sb.push_back('{name:nm, kind:k, exp:v});
    @(negedge clk); #1;
  endtask

  task automatic load_reg(int n, logic [31:0] v);
    step(S_NONE, '0, 8'h08, 5'd0, 1'b1, v);
    step(S_MDR, 16'h1 << n, 8'h00, 5'd0, 1'b0, 32'd0);
  endtask

  initial begin
    int s;
    logic [15:0] rd;
    logic [7:0]  od;
    logic [4:0]  op;

    clear_all();
    mdatain = '0;
    clr = 1'b0;
    model_reset();
    #2;
    sb.push_back('{name:"rst_bus", kind:0, exp:32'd0});
    sb.push_back('{name:"rst_mar", kind:1, exp:32'd0});
    sb.push_back('{name:"rst_ir", kind:2, exp:32'd0});
    @(negedge clk); #1;
    clr = 1'b1;
    expect_src(6, "rst_r6", 32'd0);
    expect_src(S_ZL, "rst_zl", 32'd0);

    load_reg(6, 32'd13);
    expect_src(6, "load_r6", 32'd13);
    load_reg(4, 32'd5);
    expect_src(4, "load_r4", 32'd5);
    expect_src(6, "keep_r6", 32'd13);

    step(S_PC, '0, 8'h84, 5'd12, 1'b0, 32'd0);
    expect_kind(1, "fetch_mar", 32'd0);
    expect_src(S_ZL, "fetch_z", 32'd1);
    step(S_ZL, '0, 8'h09, 5'd0, 1'b1, 32'h28918000);
    expect_src(S_PC, "fetch_pc", 32'd1);
    step(S_MDR, '0, 8'h02, 5'd0, 1'b0, 32'd0);
    expect_kind(2, "fetch_ir", 32'h28918000);

    step(6, '0, 8'h40, 5'd0, 1'b0, 32'd0);
    step(4, '0, 8'h80, 5'd7, 1'b0, 32'd0);
    step(S_ZL, 16'h0040, 8'h00, 5'd0, 1'b0, 32'd0);
    expect_src(6, "ror", 32'h68000000);
    load_reg(6, 32'd13);
    step(6, '0, 8'h40, 5'd0, 1'b0, 32'd0);
    step(4, '0, 8'h80, 5'd8, 1'b0, 32'd0);
    step(S_ZL, 16'h0040, 8'h00, 5'd0, 1'b0, 32'd0);
    expect_src(6, "rol", 32'h000001A0);

    load_reg(1, 32'hFFFFFFFA);
    load_reg(2, 32'd4);
    step(1, '0, 8'h40, 5'd0, 1'b0, 32'd0);
    step(2, '0, 8'h80, 5'd13, 1'b0, 32'd0);
    expect_src(S_ZL, "mul_lo", 32'hFFFFFFE8);
    expect_src(S_ZH, "mul_hi", 32'hFFFFFFFF);
    load_reg(1, 32'd17);
    load_reg(2, 32'd5);
    step(1, '0, 8'h40, 5'd0, 1'b0, 32'd0);
    step(2, '0, 8'h80, 5'd14, 1'b0, 32'd0);
    expect_src(S_ZL, "div_q", 32'd3);
    expect_src(S_ZH, "div_r", 32'd2);
    load_reg(2, 32'd0);
    step(2, '0, 8'h80, 5'd14, 1'b0, 32'd0);
    expect_src(S_ZL, "div0_lo", 32'd0);
    expect_src(S_ZH, "div0_hi", 32'd0);

    step(4, 16'h0010, 8'h00, 5'd0, 1'b0, 32'd0);
    expect_src(4, "self_xfer", 32'd5);

    load_reg(2, 32'hCAFE0002);
    clear_all();
    rout[2] = 1'b1;
    pc_out = 1'b1;
    sb.push_back('{name:"prio", kind:0, exp:32'hCAFE0002});
    @(negedge clk); #1;
    clear_all();
    sb.push_back('{name:"idle", kind:0, exp:32'd0});
    @(negedge clk); #1;

    drive_src(4);
    rin[5] = 1'b1;
    #2;
    clear_all();
    expect_src(5, "glitch", 32'd0);

    for (int it = 0; it < 300; it++) begin
      s = int'($urandom_range(0, 22));
      if (s == 22) s = S_NONE;
      rd = ($urandom_range(0, 2) == 0) ?
           16'h1 << $urandom_range(0, 15) : 16'h0;
      od = 8'($urandom) & 8'($urandom);
      op = ($urandom_range(0, 7) == 0) ?
           5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      if (op == 5'd14 && m_y == 32'h80000000 &&
          mbus(s) == 32'hFFFFFFFF) op = 5'd1;
      step(s, rd, od, op, 1'($urandom), $urandom);
      observe(int'($urandom_range(0, 21)), "rand");
    end

    clr = 1'b0;
    #2;
    clr = 1'b1;
    model_reset();
    expect_src(6, "clr_r6", 32'd0);
    expect_src(S_PC, "clr_pc", 32'd0);
    expect_src(S_ZL, "clr_zl", 32'd0);
    expect_kind(1, "clr_mar", 32'd0);
    expect_kind(2, "clr_ir", 32'd0);

    for (int k = 0; k < 5 && sb.size() > 0; k++)
      @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
